sprite_ram_arbiter: RTL and testbench
=====================================

Name: sprite_ram_arbiter

Overview:
- Shares the single read port of one sprite frame RAM among NUM_REQ pixel-pipeline requesters using round-robin arbitration. Example requesters: wall, player, enemy and HUD renderers.
- The target RAM has a 19-bit address, 5-bit data, synchronous read (one-cycle latency) and a separate write port.
- The block also forwards one loader write stream to that write port. It blocks read-after-write hazards on the same address.
- It sits between the per-sprite drawing logic and the frame RAM instance.

Parameters:
- NUM_REQ, 4: number of read requesters (2..8).
- ADDR_W, 19: RAM address width.
- DATA_W, 5: RAM data width.
- RAM_LAT, 1: RAM read latency in cycles (1..3); sets the depth of the tag pipeline.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- req  in  NUM_REQ  per-requester read request; must be held until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed read addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- rd_valid  out  NUM_REQ  one-hot; data for requester i is on rd_data.
- rd_data  out  DATA_W  read data, driven straight from ram_data_Out.
- wr_req  in  1  loader write request.
- wr_addr  in  ADDR_W  loader write address.
- wr_data  in  DATA_W  loader write data.
- wr_ack  out  1  write accepted this cycle.
- ram_read_address  out  ADDR_W  to the RAM read_address input.
- ram_write_address  out  ADDR_W  to the RAM write_address input.
- ram_data_In  out  DATA_W  to the RAM data_In input.
- ram_we  out  1  to the RAM we input.
- ram_data_Out  in  DATA_W  from the RAM data_Out output.

Behaviour:
- Reset:
  - Clk is the single clock. Reset_n is synchronous, active-low, and sampled only on the rising edge of Clk.
  - While Reset_n=0: gnt=0, wr_ack=0, ram_we=0.
  - On a reset edge: rr_ptr <= NUM_REQ-1 (so requester 0 has top priority first), last_addr <= 0, tag pipeline cleared. rd_valid=0 from the cycle after reset through RAM_LAT cycles after release.
- Arbitration (each cycle, combinational):
  - eligible[i] = req[i] && !(wr_req && req_addr[i]==wr_addr).
  - Search eligible starting at index rr_ptr+1 mod NUM_REQ. The first hit k receives gnt[k]=1.
  - At most one gnt bit is set. gnt=0 when nothing is eligible.
- Pointer update: on an edge where a grant was issued, rr_ptr <= k. Otherwise rr_ptr holds.
- Fairness: with all requesters continuously eligible, grants rotate 0,1,2,3,0,… and each gets exactly 1 grant per NUM_REQ cycles.
- Read address:
  - ram_read_address = req_addr[k] in a granted cycle, else last_addr.
  - last_addr <= req_addr[k] on grant, so the address does not toggle while idle.
- Handshake:
  - gnt[i] is the acknowledge. The requester may drop req or present a new address in the next cycle.
  - Back-to-back grants to the same requester are allowed when it is the only eligible requester.
- Return path:
  - A (valid, index) tag enters a RAM_LAT-deep shift pipeline on each grant.
  - rd_valid[index] asserts exactly RAM_LAT cycles after the grant cycle, for one cycle, with rd_data = ram_data_Out.
  - Bubbles propagate as valid=0.
- Write path:
  - ram_we = wr_req, ram_write_address = wr_addr, ram_data_In = wr_data, wr_ack = wr_req. All combinational; writes are never stalled.
  - A write and a read to different addresses in the same cycle both proceed.
- Hazard: a read to the address being written that cycle is masked (not granted) and retries the next cycle. It therefore returns post-write data.
- Reset mid-operation: in-flight tags are discarded and no rd_valid appears for reads granted before the reset edge. Requesters must re-request.
- Illegal input: req_addr values on non-requesting lanes are ignored.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with req=4'b1111 -> gnt=0, rd_valid=0, ram_we=0. The first cycle after release grants requester 0.
- Round robin: req=4'b1111 for 8 cycles, addresses 0x10/0x20/0x30/0x40, RAM preloaded with mem[0x10]=1, mem[0x20]=2, mem[0x30]=3, mem[0x40]=4 -> gnt sequence 1,2,4,8,1,2,4,8. rd_valid follows one cycle later with rd_data 1,2,3,4,1,2,3,4.
- Sparse: only req[2]=1 with address 0x7F for 3 consecutive cycles -> gnt=4'b0100 each cycle and rd_valid[2] on 3 consecutive cycles. req then drops to 0 -> ram_read_address stays 0x7F.
- Hazard: wr_req=1, wr_addr=0x55, wr_data=9 while req[1]=1 with address 0x55 -> gnt[1]=0 that cycle. Next cycle (wr_req=0) gnt[1]=1, then rd_data=9 with rd_valid[1].
- Concurrent write: wr_addr=0x100 plus req[0] at 0x101 -> wr_ack=1, gnt[0]=1 in the same cycle.
- Mid-flight reset: grant req[3] and pull Reset_n=0 on the next edge -> no rd_valid[3] ever appears. The pointer restarts so requester 0 wins first.

Source files
------------

// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter that shares the read port of a sprite frame RAM among
// NUM_REQ pixel-pipeline requesters. It also forwards one loader write stream
// to the RAM write port and masks reads that hit the address being written.
//
// Handshake: a requester holds req[i] (with a stable req_addr lane) until it
// sees gnt[i]=1 in the same cycle; gnt[i] is the acknowledge, and the request
// may be dropped or a new address presented on the following cycle. Read data
// returns exactly RAM_LAT cycles after the grant as a one-cycle rd_valid[i]
// pulse with rd_data. Writes are accepted unconditionally (wr_ack = wr_req).
module sprite_ram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 5,
  parameter int RAM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      wr_req,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ack,
  output logic [ADDR_W-1:0]         ram_read_address,
  output logic [ADDR_W-1:0]         ram_write_address,
  output logic [DATA_W-1:0]         ram_data_In,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_data_Out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [RAM_LAT-1:0] r_tag_v;
  logic [IDX_W-1:0]   r_tag_idx [RAM_LAT];

  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  logic [ADDR_W-1:0]  w_sel_addr;

  // A lane is eligible when requesting and not colliding with this cycle's write.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req[i] && !(wr_req && (req_addr[i*ADDR_W +: ADDR_W] == wr_addr));
    end
  end

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] w_j;
    j     = 0;
    w_j   = '0;
    w_any = 1'b0;
    w_sel = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      j = int'(r_rr_ptr) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      w_j = IDX_W'(j);
      if (!w_any && w_elig[w_j]) begin
        w_any = 1'b1;
        w_sel = w_j;
      end
    end
    // Nothing is granted while reset is held.
    w_any      = w_any && Reset_n;
    w_sel_addr = req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
  end

  // Grant, read address (held while idle) and write pass-through.
  always_comb begin
    gnt               = w_any ? (NUM_REQ'(1) << w_sel) : '0;
    ram_read_address  = w_any ? w_sel_addr : r_last_addr;
    ram_we            = wr_req && Reset_n;
    wr_ack            = wr_req && Reset_n;
    ram_write_address = wr_addr;
    ram_data_In       = wr_data;
  end

  // Pointer, idle address and the tag pipeline that tracks in-flight reads.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_last_addr <= '0;
      r_tag_v     <= '0;
      for (int s = 0; s < RAM_LAT; s++) r_tag_idx[s] <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr    <= w_sel;
        r_last_addr <= w_sel_addr;
      end
      r_tag_v[0]   <= w_any;
      r_tag_idx[0] <= w_sel;
      for (int s = 1; s < RAM_LAT; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  // Return path: gating with Reset_n drops a tag that is due while reset is low.
  always_comb begin
    rd_valid = (Reset_n && r_tag_v[RAM_LAT-1]) ? (NUM_REQ'(1) << r_tag_idx[RAM_LAT-1]) : '0;
    rd_data  = ram_data_Out;
  end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Bench for sprite_ram_arbiter: behavioural sync-read RAM, directed cycles
// with hand-computed grants, and an expected-read queue drained by a monitor.
module tb_sprite_ram_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [75:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  rd_valid;
  logic [4:0]  rd_data;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [4:0]  wr_data;
  logic        wr_ack;
  logic [18:0] ram_read_address;
  logic [18:0] ram_write_address;
  logic [4:0]  ram_data_In;
  logic        ram_we;
  logic [4:0]  ram_data_Out;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];   // {rd_valid one-hot, rd_data}

  // Clock / reset block
  always #5 Clk = ~Clk;

  sprite_ram_arbiter #(.NUM_REQ(4), .ADDR_W(19), .DATA_W(5), .RAM_LAT(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .ram_read_address(ram_read_address),
    .ram_write_address(ram_write_address), .ram_data_In(ram_data_In),
    .ram_we(ram_we), .ram_data_Out(ram_data_Out)
  );

  // Behavioural frame RAM: one-cycle synchronous read, separate write port.
  logic [4:0] mem [0:(1<<19)-1];
  always @(posedge Clk) begin
    if (ram_we) mem[ram_write_address] <= ram_data_In;
    ram_data_Out <= mem[ram_read_address];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_addr(input logic [18:0] a0, input logic [18:0] a1,
                          input logic [18:0] a2, input logic [18:0] a3);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic expect_rd(input logic [3:0] oh, input logic [4:0] d);
    exp_q.push_back({oh, d});
  endtask

  // Driver: inputs already applied; check combinational outputs mid-cycle.
  task automatic cyc(input logic [3:0] eg, input logic ea, input logic ca,
                     input logic [18:0] er, input string nm);
    @(negedge Clk);
    check({nm, "_gnt"}, 32'(gnt), 32'(eg));
    check({nm, "_wr_ack"}, 32'(wr_ack), 32'(ea));
    check({nm, "_ram_we"}, 32'(ram_we), 32'(ea));
    if (ca) check({nm, "_rd_addr"}, 32'(ram_read_address), 32'(er));
    @(posedge Clk);
    #1;
  endtask

  // Monitor / scoreboard: every rd_valid pulse must match the queue head.
  always @(negedge Clk) begin
    logic [8:0] e;
    if (rd_valid !== 4'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got valid=%b data=%0d expected no read", rd_valid, rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_valid", 32'(rd_valid), 32'(e[8:5]));
        check("rd_data", 32'(rd_data), 32'(e[4:0]));
      end
    end
  end

  logic [18:0] pre_a [6] = '{19'h10, 19'h20, 19'h30, 19'h40, 19'h7F, 19'h101};
  logic [4:0]  pre_d [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd12};
  logic [18:0] rr_a  [4] = '{19'h10, 19'h20, 19'h30, 19'h40};

  initial begin
    Reset_n = 1'b0; req = '0; req_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Preload RAM through the write path; no reads yet, read address idles at 0.
    for (int i = 0; i < 6; i++) begin
      wr_req = 1'b1; wr_addr = pre_a[i]; wr_data = pre_d[i];
      @(negedge Clk);
      check("pre_wr_addr", 32'(ram_write_address), 32'(pre_a[i]));
      check("pre_wr_data", 32'(ram_data_In), 32'(pre_d[i]));
      @(posedge Clk);
      #1;
      cyc(4'b0, 1'b1, 1'b1, 19'h0, "preload");
    end
    wr_req = 1'b0;

    // Reset held 3 cycles with everyone requesting and a write pending.
    Reset_n = 1'b0; req = 4'hF; set_addr(19'h10, 19'h20, 19'h30, 19'h40);
    wr_req = 1'b1; wr_addr = 19'h200; wr_data = 5'd3;
    for (int i = 0; i < 3; i++) cyc(4'b0, 1'b0, 1'b0, 19'h0, "reset");
    wr_req = 1'b0;
    Reset_n = 1'b1;

    // Round robin: 1,2,4,8,1,2,4,8 with data 1,2,3,4,...
    for (int i = 0; i < 8; i++) begin
      expect_rd(4'(1 << (i % 4)), 5'((i % 4) + 1));
      cyc(4'(1 << (i % 4)), 1'b0, 1'b1, rr_a[i % 4], "rr");
    end

    // Sparse: lone requester 2 wins back-to-back; idle holds last address.
    req = 4'b0100; set_addr(19'h0, 19'h0, 19'h7F, 19'h0);
    for (int i = 0; i < 3; i++) begin
      expect_rd(4'b0100, 5'd7);
      cyc(4'b0100, 1'b0, 1'b1, 19'h7F, "sparse");
    end
    req = 4'b0; set_addr(19'h1, 19'h2, 19'h3, 19'h4);
    cyc(4'b0, 1'b0, 1'b1, 19'h7F, "idle_hold");
    cyc(4'b0, 1'b0, 1'b1, 19'h7F, "idle_hold");

    // Hazard: read to the address being written is masked, retries next cycle.
    wr_req = 1'b1; wr_addr = 19'h55; wr_data = 5'd9;
    req = 4'b0010; set_addr(19'h0, 19'h55, 19'h0, 19'h0);
    cyc(4'b0, 1'b1, 1'b1, 19'h7F, "hazard_mask");
    wr_req = 1'b0;
    expect_rd(4'b0010, 5'd9);
    cyc(4'b0010, 1'b0, 1'b1, 19'h55, "hazard_retry");
    req = 4'b0;
    cyc(4'b0, 1'b0, 1'b1, 19'h55, "hazard_idle");

    // Concurrent write and read to different addresses, then read back the write.
    wr_req = 1'b1; wr_addr = 19'h100; wr_data = 5'd17;
    req = 4'b0001; set_addr(19'h101, 19'h0, 19'h0, 19'h0);
    expect_rd(4'b0001, 5'd12);
    cyc(4'b0001, 1'b1, 1'b1, 19'h101, "concurrent");
    wr_req = 1'b0; set_addr(19'h100, 19'h0, 19'h0, 19'h0);
    expect_rd(4'b0001, 5'd17);
    cyc(4'b0001, 1'b0, 1'b1, 19'h100, "readback");

    // Mid-flight reset: grant to 3 must never return; pointer restarts at 0.
    req = 4'b1000; set_addr(19'h0, 19'h0, 19'h0, 19'h40);
    cyc(4'b1000, 1'b0, 1'b1, 19'h40, "mid_grant");
    Reset_n = 1'b0; req = 4'b0;
    cyc(4'b0, 1'b0, 1'b0, 19'h0, "mid_reset");
    cyc(4'b0, 1'b0, 1'b0, 19'h0, "mid_reset");
    Reset_n = 1'b1; req = 4'hF; set_addr(19'h10, 19'h20, 19'h30, 19'h40);
    expect_rd(4'b0001, 5'd1);
    cyc(4'b0001, 1'b0, 1'b1, 19'h10, "restart");
    req = 4'b0;
    for (int i = 0; i < 3; i++) cyc(4'b0, 1'b0, 1'b1, 19'h10, "drain");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
